pe_dispatcher: RTL
==================

// Module: pe_dispatcher
// PURPOSE
//  Initiator side of the PE job interface: collects one row and one column of N signed elements
//  from an upstream valid/ready stream, then presents both as parallel vectors to a PE with a
//  one-cycle pe_init pulse. It waits for the PE to flag completion, captures the dot-product
//  total and error flag, and returns them on a downstream valid/ready port.
//  Sits between the operand fetch logic and each PE of the matrix multiplier array.
// PARAMETERS
//  N            8             elements per row/column (vector length handed to the PE)
//  DATA_WIDTH   16            signed operand width
//  ACCUM_WIDTH  2*DATA_WIDTH  signed result width (matches PE total)
//  TIMEOUT      4*N           max cycles in WAIT before the job is aborted with an error
// PORTS
//  clk          in   1                   single clock, all state on rising edge
//  rst          in   1                   synchronous, active-high reset
//  in_valid     in   1                   upstream operand pair valid
//  in_ready     out  1                   dispatcher accepts a pair this cycle
//  in_row_elem  in   DATA_WIDTH          row element, signed
//  in_col_elem  in   DATA_WIDTH          column element, signed
//  pe_init      out  1                   one-cycle job start strobe to the PE
//  pe_row       out  DATA_WIDTH x [0:N-1] row vector to the PE, index 0 = first beat
//  pe_col       out  DATA_WIDTH x [0:N-1] column vector to the PE, index 0 = first beat
//  pe_total     in   ACCUM_WIDTH         PE dot-product result
//  pe_rdy       in   1                   PE job complete
//  pe_err       in   1                   PE overflow/error flag
//  out_valid    out  1                   result available downstream
//  out_ready    in   1                   downstream accepts result
//  out_total    out  ACCUM_WIDTH         captured result, signed
//  out_err      out  1                   pe_err captured, or timeout
//  busy         out  1                   high whenever state != LOAD or beat count != 0
// BEHAVIOUR
//  - Reset (rst=1 at clk edge) has priority over all other activity, including mid-job:
//    state=LOAD, beat count=0, timer=0, pe_init=0, out_valid=0, out_total=0, out_err=0, busy=0.
//    pe_row and pe_col clear to 0. in_ready goes to 1 on the cycle after reset is released.
//  - FSM: LOAD -> ISSUE -> WAIT -> DRAIN -> LOAD.
//  - LOAD state
//    - in_ready=1.
//    - Each in_valid&in_ready beat writes pe_row[cnt]/pe_col[cnt] and increments cnt.
//    - The beat with cnt==N-1 wraps cnt to 0 and moves to ISSUE. in_ready drops in the next cycle.
//    - in_valid=0 inserts bubbles; cnt holds.
//  - ISSUE state: pe_init=1 for exactly one cycle, then WAIT. in_ready=0.
//  - pe_row and pe_col are stable from ISSUE until the next LOAD beat overwrites them.
//  - WAIT state
//    - Timer counts from 0. pe_rdy is ignored on the first WAIT cycle (guards against stale rdy).
//    - From the second WAIT cycle on, pe_rdy=1 captures out_total<=pe_total and out_err<=pe_err,
//      then moves to DRAIN.
//    - Timer reaching TIMEOUT with no pe_rdy: out_total<=0, out_err<=1, then DRAIN.
//    - If pe_rdy and timer expiry happen in the same cycle, pe_rdy wins (normal capture).
//  - DRAIN state
//    - out_valid=1. out_total and out_err are held stable until out_valid&out_ready.
//    - On that handshake: out_valid drops in the next cycle and the FSM returns to LOAD.
//    - If out_ready is already high on the first DRAIN cycle, the result is consumed in that cycle.
//  - Latency:
//    - Last input beat to pe_init: 1 cycle.
//    - pe_rdy accepted to out_valid: 1 cycle.
//    - Minimum job, with no bubbles and out_ready=1: N + 4 cycles from the first beat to the
//      next in_ready.
//  - Arithmetic: no arithmetic on data. Values pass through sign-preserving. Timer width is
//    $clog2(TIMEOUT+1) and saturates; it does not wrap.
//  - pe_init never asserts outside ISSUE. Only one job is outstanding at a time.
// TESTING  (N=4, DATA_WIDTH=16, TIMEOUT=16; bench PE model sets pe_rdy 5 cycles after pe_init)
//  1. Basic job
//     - Stimulus: row {1,2,3,4}, col {5,6,7,8}, back-to-back; PE model returns total=70.
//     - Required: pe_init pulses 1 cycle; pe_row={1,2,3,4}; out_total=70, out_err=0.
//  2. Signed data with bubbles
//     - Stimulus: row {-3,0,7,-1}, col {2,9,-4,5}, in_valid low on alternate cycles.
//     - Required: vectors assembled in order; total=-39 propagated; cnt holds during bubbles.
//  3. Downstream backpressure
//     - Stimulus: out_ready low for 10 cycles after out_valid rises.
//     - Required: out_valid, out_total and out_err stay stable; in_ready stays 0; a single
//       handshake returns the FSM to LOAD.
//  4. Timeout
//     - Stimulus: PE model never asserts pe_rdy.
//     - Required: after 16 WAIT cycles, out_valid=1, out_err=1, out_total=0.
//  5. Stale rdy and pe_err
//     - Stimulus: pe_rdy held high continuously; then a job where PE reports pe_err=1.
//     - Required: capture no earlier than the second WAIT cycle; out_err=1 with pe_total passed
//       through.
//  6. Mid-job reset
//     - Stimulus: rst=1 after 2 beats, and separately during WAIT.
//     - Required: next cycle all outputs at reset values; the next job's first beat lands in
//       pe_row[0].

Source files
------------

// File: rtl/pe_dispatcher.sv
// PE job dispatcher: gathers N row/column operand pairs from a valid/ready
// stream, launches one PE job with a single-cycle pe_init strobe, waits for
// completion or timeout, and returns the captured result downstream.
//
// state | meaning
// ------+-----------------------------------------------------------------
// LOAD  | accepting operand beats into pe_row/pe_col, in_ready high
// ISSUE | vectors complete, pe_init high for this single cycle
// WAIT  | job outstanding; pe_rdy ignored on first cycle; timer running
// DRAIN | result held on out_total/out_err with out_valid high

module pe_dispatcher #(
   parameter int N           = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
   parameter int TIMEOUT     = 4*N
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_WIDTH-1:0]  in_row_elem,
   input  logic signed [DATA_WIDTH-1:0]  in_col_elem,
   output logic                          pe_init,
   output logic signed [DATA_WIDTH-1:0]  pe_row [0:N-1],
   output logic signed [DATA_WIDTH-1:0]  pe_col [0:N-1],
   input  logic signed [ACCUM_WIDTH-1:0] pe_total,
   input  logic                          pe_rdy,
   input  logic                          pe_err,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [ACCUM_WIDTH-1:0] out_total,
   output logic                          out_err,
   output logic                          busy
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   // Timer is a down-counter: loading TIMEOUT-1 in ISSUE gives exactly
   // TIMEOUT WAIT cycles before the terminal count aborts the job.
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [TMR_W-1:0] timer;
   logic             wait_first;
   logic             rst_done;
   logic             beat;
   logic             last_beat;
   logic             rdy_ok;
   logic             tmr_tc;

   // Next-state decode and handshake/status outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = (state == LOAD) && rst_done;
      pe_init   = (state == ISSUE);
      out_valid = (state == DRAIN);
      busy      = (state != LOAD) || (cnt != '0);
      beat      = in_valid && in_ready;
      last_beat = beat && (cnt == CNT_LAST);
      rdy_ok    = pe_rdy && !wait_first;
      tmr_tc    = (timer == '0);
      case (state)
         LOAD:    if (last_beat) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (rdy_ok || tmr_tc) state_nxt = DRAIN;
         DRAIN:   if (out_ready) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // State register; in_ready is held off until the cycle after reset release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD;
         rst_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         rst_done <= 1'b1;
      end
   end

   // Beat counter: wraps to zero on the beat that completes the vectors.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (last_beat) begin
         cnt <= '0;
      end else if (beat) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Operand vectors: only a LOAD beat writes them, so they stay stable for the PE.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            pe_row[i] <= '0;
            pe_col[i] <= '0;
         end
      end else if (beat) begin
         pe_row[cnt] <= in_row_elem;
         pe_col[cnt] <= in_col_elem;
      end
   end

   // WAIT timer (saturating down-counter) and first-cycle stale-rdy guard.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer      <= '0;
         wait_first <= 1'b0;
      end else if (state == ISSUE) begin
         timer      <= TMR_LOAD;
         wait_first <= 1'b1;
      end else if (state == WAIT) begin
         wait_first <= 1'b0;
         if (!tmr_tc) timer <= timer - TMR_W'(1);
      end
   end

   // Result capture: PE completion has priority over a coincident timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_total <= '0;
         out_err   <= 1'b0;
      end else if (state == WAIT) begin
         if (rdy_ok) begin
            out_total <= pe_total;
            out_err   <= pe_err;
         end else if (tmr_tc) begin
            out_total <= '0;
            out_err   <= 1'b1;
         end
      end
   end

endmodule
